// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: binary search MSB first, one bit per SETTLE_CYCLES; result after WIDTH*SETTLE_CYCLES cycles.
// Result is held with result_valid until result_ready; start is only honoured in IDLE, so no new conversion runs while blocked.
module sar_adc_ctrl #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    IDX_MSB  = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dac_code_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            bit_idx_q      <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            dac_code_q     <= dac_code_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            bit_idx_q      <= bit_idx_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dac_code_d     = dac_code_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        bit_idx_d      = bit_idx_q;
        cnt_d          = cnt_q;
        trial          = dac_code_q;
        case (state_q)
            IDLE: begin
                dac_code_d = '0;
                if (start) begin
                    state_d    = CONV;
                    bit_idx_d  = IDX_MSB;
                    dac_code_d = CODE_MSB;
                    cnt_d      = '0;
                end
            end
            CONV: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Resolve the current bit and, in the same edge, raise the next trial bit.
                    if (!comp_in) begin
                        trial[bit_idx_q] = 1'b0;
                    end
                    cnt_d = '0;
                    if (bit_idx_q != '0) begin
                        trial[bit_idx_q - 1'b1] = 1'b1;
                        bit_idx_d               = bit_idx_q - 1'b1;
                    end else begin
                        state_d        = DONE;
                        result_d       = trial;
                        result_valid_d = 1'b1;
                    end
                    dac_code_d = trial;
                end
            end
            DONE: begin
                if (result_valid_q && result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    dac_code_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dac_code     = dac_code_q;
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, conversion-level reference model, randomized codes and backpressure.
module tb_sar_adc_ctrl;
    localparam int W = 10;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         result_ready = 1'b0;
    logic         comp_in;
    logic [W-1:0] vin = '0;
    logic [W-1:0] dac_code, result;
    logic         busy, result_valid;

    logic         start1 = 1'b0;
    logic         comp1;
    logic [W-1:0] vin1 = '0;
    logic [W-1:0] dac1, result1;
    logic         busy1, valid1;

    assign comp_in = (vin >= dac_code);
    assign comp1   = (vin1 >= dac1);

    always #5 clk = ~clk;

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .comp_in(comp_in),
        .dac_code(dac_code), .busy(busy), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .comp_in(comp1),
        .dac_code(dac1), .busy(busy1), .result(result1),
        .result_valid(valid1), .result_ready(1'b1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase (0 idle, 1 converting, 2 result pending), edges elapsed, latched input.
    int m_ph = 0, m_e = 0, m_vin = 0, m_res = 0;
    bit chk_en = 1'b0;

    // Trial code after k decisions: top k bits of the answer, then a 1 at the bit under test.
    function automatic int trial_code(input int v, input int k);
        return ((v >> (W - k)) << (W - k)) | (1 << (W - 1 - k));
    endfunction

    function automatic int exp_dac();
        if (m_ph == 0) return 0;
        if (m_ph == 2) return m_res;
        return trial_code(m_vin, m_e / S);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_e = 0; m_res = 0;
        end else begin
            case (m_ph)
                0: if (start) begin m_ph = 1; m_e = 0; m_vin = int'(vin); end
                1: begin
                    m_e++;
                    if (m_e == W * S) begin m_ph = 2; m_res = m_vin; end
                end
                default: if (result_ready) m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dac_code", int'(dac_code), exp_dac());
            check("model_busy", int'(busy), int'(m_ph != 0));
            check("model_result_valid", int'(result_valid), int'(m_ph == 2));
            check("model_result", int'(result), m_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] seq [W];

    task automatic do_conv(input int v, input int hold, input bit poke, output int res, output int lat);
        vin = W'(v);
        start = 1'b1;
        result_ready = 1'b0;
        tick();
        start = 1'b0;
        lat = 0;
        while (!result_valid && lat < 100) begin
            if ((lat % S) == 0 && (lat / S) < W) seq[lat / S] = dac_code;
            start = poke && (lat == 5);
            tick();
            lat++;
        end
        start = 1'b0;
        if (!result_valid) begin
            n_vec++; n_err++;
            $display("FAIL conv_timeout: result_valid still 0 after %0d cycles, vin=%0d", lat, v);
        end
        for (int i = 0; i < hold; i++) begin
            start = (i == 2);
            tick();
        end
        if (hold > 0) check("held_valid", int'(result_valid), 1);
        res = int'(result);
        result_ready = 1'b1;
        start = poke;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check("busy_after_hs", int'(busy), 0);
        check("result_kept", int'(result), res);
    endtask

    initial begin
        int res, lat;
        int exp_seq [W] = '{'h200, 'h100, 'h180, 'h140, 'h160, 'h150, 'h158, 'h154, 'h156, 'h155};
        int last, nrise;
        bit prev;

        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_dac_code", int'(dac_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_result", int'(result), 0);
        rst = 1'b0;
        tick();

        do_conv(512, 0, 0, res, lat);
        check("res_512", res, 'h200);
        check("latency_s2", lat, 20);
        check("first_trial_512", int'(seq[0]), 'h200);
        do_conv(1023, 0, 0, res, lat);
        check("res_1023", res, 'h3FF);
        do_conv(0, 0, 0, res, lat);
        check("res_0", res, 'h000);
        check("first_trial_0", int'(seq[0]), 'h200);
        check("msb_cleared_0", int'(seq[1]), 'h100);
        do_conv(341, 0, 0, res, lat);
        check("res_341", res, 'h155);
        for (int i = 0; i < W; i++) check("trial_seq_341", int'(seq[i]), exp_seq[i]);
        do_conv(700, 0, 0, res, lat);
        check("res_700", res, 'h2BC);

        do_conv(600, 5, 1, res, lat);
        check("res_backpressure", res, 600);

        do_conv(123, 0, 1, res, lat);
        check("res_poke", res, 123);

        // Abort at bit 6: its decision edge is N+8, so reset lands on that edge.
        vin = W'(900);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_dac_code", int'(dac_code), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        for (int i = 0; i < 30; i++) begin
            check("abort_no_valid", int'(result_valid), 0);
            tick();
        end

        vin = W'(700);
        result_ready = 1'b1;
        start = 1'b1;
        last = -1;
        nrise = 0;
        prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (result_valid && !prev) begin
                if (last >= 0) check("b2b_period", c - last, 22);
                last = c;
                nrise++;
            end
            prev = result_valid;
        end
        check("b2b_rises", int'(nrise >= 4), 1);
        start = 1'b0;
        repeat (30) tick();
        result_ready = 1'b0;
        check("b2b_idle", int'(busy), 0);

        for (int i = 0; i < 25; i++) begin
            int v;
            v = int'($urandom_range(0, 1023));
            do_conv(v, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), res, lat);
            check("rand_res", res, v);
        end

        vin1 = W'(341);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s1_busy", int'(busy1), 1);
        lat = 0;
        while (!valid1 && lat < 50) begin
            tick();
            lat++;
        end
        check("latency_s1", lat, 10);
        check("s1_res_341", int'(result1), 'h155);
        tick();
        check("s1_idle", int'(busy1), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation ADC controller, the conversion-side counterpart of the DAC path in the ADC/DAC system. It drives a trial code onto the internal DAC, samples an external comparator (analog input >= DAC output), and resolves one bit per step, MSB first. The finished code is delivered to the digital side over a valid/ready handshake.

Parameters:
WIDTH, 10, resolution in bits; dac_code and result width.
SETTLE_CYCLES, 2, clock cycles each trial code is held before comp_in is sampled; must be >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  conversion request; accepted only in IDLE.
comp_in  input  1  comparator output; 1 = analog input >= current dac_code.
dac_code  output  WIDTH  trial code driving the DAC.
busy  output  1  high from start acceptance until the result handshake completes.
result  output  WIDTH  converted code; held stable until the next conversion completes.
result_valid  output  1  result available; held until accepted.
result_ready  input  1  consumer accepts result when high with result_valid.

Behaviour:
- Interface: one clock domain (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, dac_code=0, busy=0, result=0, result_valid=0, and internal bit index and settle counter cleared. Reset takes priority in any state; a conversion in progress is discarded with no partial result.
- States: IDLE, CONV, DONE.
- IDLE:
  - dac_code=0, busy=0.
  - start=1 at edge N: state=CONV, bit_idx=WIDTH-1, dac_code=1<<(WIDTH-1) (0x200 for WIDTH=10), settle counter=0, busy=1.
  - start=0: stay in IDLE.
- CONV:
  - The settle counter increments each cycle. dac_code is stable while the counter is below SETTLE_CYCLES-1.
  - On the cycle the counter equals SETTLE_CYCLES-1, comp_in is sampled at that edge:
    - comp_in=0: clear dac_code[bit_idx].
    - comp_in=1: keep dac_code[bit_idx].
    - bit_idx>0: set dac_code[bit_idx-1], decrement bit_idx, reset the counter.
    - bit_idx==0: move to DONE.
  - Bit k (WIDTH-1 down to 0) is sampled at edge N+(WIDTH-k)*SETTLE_CYCLES.
- DONE entry (edge N+WIDTH*SETTLE_CYCLES):
  - result = final code, with bit 0 already resolved at the same edge.
  - result_valid=1.
  - dac_code holds the final code.
  - For the defaults, result_valid rises exactly 20 cycles after start is accepted.
- DONE:
  - result_valid stays high and result stays stable while result_ready=0. There is no timeout.
  - result_valid=1 and result_ready=1 at an edge: result_valid=0, state=IDLE, busy=0, dac_code=0. result keeps its value.
- start is ignored in CONV and in DONE, including the handshake cycle itself. start must be re-asserted in IDLE; a start pulse is not queued.
- result_ready is ignored when result_valid=0.
- Comparator arithmetic: no filtering. comp_in is a single sample per bit and is treated as synchronous to clk.
- Back-to-back conversions:
  - The minimum period is WIDTH*SETTLE_CYCLES + 2 cycles: the handshake edge plus one IDLE cycle to accept start.
  - If start is held high continuously, a new conversion begins on the edge after returning to IDLE.

Test Plan:
1. Reset/idle: hold rst for 2 cycles -> dac_code=0, busy=0, result_valid=0, result=0. Assert rst for 1 cycle mid-conversion (bit 6) -> next cycle state IDLE, all outputs at reset values, result_valid never rises.
2. Mid-scale, min and max: bench comparator comp_in=(vin>=dac_code), result_ready=1.
   - vin=512 -> result=0x200.
   - vin=1023 -> result=0x3FF.
   - vin=0 -> result=0x000.
   - Each run shows dac_code starting at 0x200, and bit 9 is cleared at the first decision for vin=0.
3. Arbitrary codes: vin=341 -> result=0x155, with dac_code trial sequence 0x200, 0x100, 0x180, 0x140, 0x160, 0x150, 0x158, 0x154, 0x156, 0x155. Also vin=700 -> result=0x2BC.
4. Latency: SETTLE_CYCLES=2 and start accepted at edge N -> result_valid first high after edge N+20, busy high from edge N. Repeat with SETTLE_CYCLES=1 -> result_valid after edge N+10.
5. Backpressure: result_ready=0 for 5 cycles after result_valid rises -> result_valid, result and busy stay constant. A start pulse during those cycles is ignored. result_ready=1 -> one-cycle handshake, then IDLE with busy=0 and result retained.
6. Start while busy / continuous start: pulse start at cycle 5 of a conversion -> no restart, and the final result is unchanged. Hold start=1 continuously with result_ready=1 -> conversions repeat with a period of exactly 22 cycles.
